// File: rtl/age_order_pkg.sv
// Shared age-matrix types and the oldest-of-mask reduction used by the age ordering tracker.
package age_order_pkg;

  localparam int AO_ENTRY_COUNT = 16;
  localparam int AO_ENTRY_TAG   = $clog2(AO_ENTRY_COUNT);

  typedef logic [AO_ENTRY_COUNT-1:0] age_row_t;
  typedef age_row_t [AO_ENTRY_COUNT-1:0] age_mat_t;

  // mat[j][i]=1 means j is older than i; an entry wins when no other masked entry is older.
  function automatic age_row_t oldest_of(input age_mat_t mat, input age_row_t mask);
    age_row_t grant;
    grant = mask;
    for (int i = 0; i < AO_ENTRY_COUNT; i++) begin
      for (int j = 0; j < AO_ENTRY_COUNT; j++) begin
        grant[i] = grant[i] & ~(mask[j] & mat[j][i]);
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/age_order_chk.sv
// Protocol and matrix-consistency assertions for the age ordering tracker.
module age_order_chk
  import age_order_pkg::*;
#(
  parameter int ENQ_WIDTH = 2
)(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush_i,
  input  logic [ENQ_WIDTH-1:0]                  enq_vld_i,
  input  logic [ENQ_WIDTH-1:0][AO_ENTRY_TAG-1:0] enq_tag_i,
  input  age_row_t                              deq_mask_i,
  input  age_row_t                              vld_i,
  input  age_mat_t                              older_i
);

  for (genvar p = 0; p < ENQ_WIDTH; p++) begin : g_enq
    a_enq_free: assert property (@(posedge clk) disable iff (rst)
      (enq_vld_i[p] && !flush_i) |-> (!vld_i[enq_tag_i[p]] || deq_mask_i[enq_tag_i[p]]));
    for (genvar q = p + 1; q < ENQ_WIDTH; q++) begin : g_dup
      a_enq_uniq: assert property (@(posedge clk) disable iff (rst)
        !(enq_vld_i[p] && enq_vld_i[q] && (enq_tag_i[p] == enq_tag_i[q])));
    end
  end

  for (genvar i = 0; i < AO_ENTRY_COUNT; i++) begin : g_row
    a_row_vld: assert property (@(posedge clk) disable iff (rst)
      ((older_i[i] & ~vld_i) == '0) && !older_i[i][i] && (vld_i[i] || (older_i[i] == '0)));
    for (genvar j = i + 1; j < AO_ENTRY_COUNT; j++) begin : g_pair
      a_total: assert property (@(posedge clk) disable iff (rst)
        (vld_i[i] && vld_i[j]) |-> (older_i[i][j] ^ older_i[j][i]));
    end
  end

endmodule

// File: rtl/age_order_pick.sv
// Combinational one-hot oldest selection of a request mask against the age matrix.
module age_order_pick
  import age_order_pkg::*;
(
  input  age_mat_t i_mat,
  input  age_row_t i_mask,
  output age_row_t o_grant
);

  assign o_grant = oldest_of(i_mat, i_mask);

endmodule

// File: rtl/age_order_matrix_multi_head.sv
// Age-matrix ordering tracker: multi-port enq/deq, K-oldest select grants, registered N-oldest heads.
// Define AGE_ORDER_KILL_EN to build the younger-than kill used for speculative recovery.
module age_order_matrix_multi_head
  import age_order_pkg::*;
#(
  parameter  int ENQ_WIDTH   = 2,
  parameter  int DEQ_WIDTH   = 2,
  parameter  int SEL_WIDTH   = 2,
  parameter  int SEL_DEPTH   = 2,
  parameter  int HEAD_CNT    = 2,
  localparam int ENTRY_COUNT = AO_ENTRY_COUNT,
  localparam int ENTRY_TAG   = AO_ENTRY_TAG
)(
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [ENQ_WIDTH-1:0]                                 enq_vld_i,
  input  logic [ENQ_WIDTH-1:0][ENTRY_TAG-1:0]                  enq_tag_i,
  input  logic [DEQ_WIDTH-1:0]                                 deq_vld_i,
  input  logic [DEQ_WIDTH-1:0][ENTRY_TAG-1:0]                  deq_tag_i,
  input  logic [SEL_WIDTH-1:0][ENTRY_COUNT-1:0]                sel_mask_i,
  output logic [SEL_WIDTH-1:0][SEL_DEPTH-1:0][ENTRY_COUNT-1:0] sel_grant_o,
  input  logic                                                 kill_vld_i,
  input  logic [ENTRY_TAG-1:0]                                 kill_tag_i,
  input  logic                                                 kill_incl_i,
  input  logic                                                 flush_i,
  output logic [ENTRY_COUNT-1:0]                               vld_mask_o,
  output logic [HEAD_CNT-1:0][ENTRY_COUNT-1:0]                 head_mask_o,
  output logic [ENTRY_COUNT-1:0]                               killed_mask_o
);

  age_row_t                             r_vld;
  age_mat_t                             r_older;
  logic [HEAD_CNT-1:0][ENTRY_COUNT-1:0] r_head;

  age_row_t w_deq_mask;
  age_row_t w_killed;
  logic     w_kill_act;
  logic     w_kill_req;
  age_row_t w_surv;
  age_row_t w_enq_seen;
  age_row_t w_vld_pre;
  age_mat_t w_older_pre;
  age_row_t w_vld_n;
  age_mat_t w_older_n;
  logic     w_upd;
  age_row_t w_head_rem [HEAD_CNT];
  age_row_t w_head_n   [HEAD_CNT];

  // Collapse the dequeue ports into one release mask.
  always_comb begin
    w_deq_mask = '0;
    for (int p = 0; p < DEQ_WIDTH; p++) begin
      w_deq_mask = w_deq_mask | (age_row_t'(deq_vld_i[p]) << deq_tag_i[p]);
    end
  end

`ifdef AGE_ORDER_KILL_EN
  // Kill removes everything younger than a valid reference, optionally the reference too.
  always_comb begin
    w_kill_act = kill_vld_i & r_vld[kill_tag_i] & ~flush_i;
    w_killed   = '0;
    if (w_kill_act) begin
      w_killed = r_older[kill_tag_i] | (age_row_t'(kill_incl_i) << kill_tag_i);
    end else begin
      w_killed = '0;
    end
  end
  assign w_kill_req = kill_vld_i;
`else
  logic w_unused_kill;
  assign w_unused_kill = ^{kill_vld_i, kill_tag_i, kill_incl_i};
  assign w_kill_act    = 1'b0;
  assign w_killed      = '0;
  assign w_kill_req    = 1'b0;
`endif

  assign killed_mask_o = w_killed;

  // Survivors keep their mutual order; each accepted enqueue lands younger than everything before it.
  always_comb begin
    logic                 w_hit;
    logic [ENTRY_TAG-1:0] w_tag;
    w_surv      = r_vld & ~w_deq_mask & ~w_killed;
    w_enq_seen  = '0;
    w_vld_pre   = w_surv;
    w_older_pre = '0;
    w_hit       = 1'b0;
    w_tag       = '0;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      w_older_pre[i] = r_older[i] & w_surv & {ENTRY_COUNT{w_surv[i]}};
    end
    for (int p = 0; p < ENQ_WIDTH; p++) begin
      w_hit = enq_vld_i[p] & ~w_kill_act;
      w_tag = enq_tag_i[p];
      w_older_pre[w_tag] = w_older_pre[w_tag] & ~{ENTRY_COUNT{w_hit}};
      for (int k = 0; k < ENTRY_COUNT; k++) begin
        w_older_pre[k][w_tag] = w_hit ? (w_surv[k] | w_enq_seen[k]) : w_older_pre[k][w_tag];
      end
      w_vld_pre[w_tag]  = w_vld_pre[w_tag] | w_hit;
      w_enq_seen[w_tag] = w_enq_seen[w_tag] | w_hit;
    end
  end

  assign w_vld_n   = flush_i ? '0 : w_vld_pre;
  assign w_older_n = flush_i ? '0 : w_older_pre;
  assign w_upd     = (|enq_vld_i) | (|deq_vld_i) | w_kill_req | flush_i;

  for (genvar s = 0; s < SEL_WIDTH; s++) begin : g_sel
    age_row_t w_sel_rem [SEL_DEPTH];
    assign w_sel_rem[0] = sel_mask_i[s] & r_vld;
    for (genvar d = 0; d < SEL_DEPTH; d++) begin : g_depth
      age_order_pick u_pick (
        .i_mat   (r_older),
        .i_mask  (w_sel_rem[d]),
        .o_grant (sel_grant_o[s][d])
      );
      if (d < SEL_DEPTH - 1) begin : g_rem
        assign w_sel_rem[d+1] = w_sel_rem[d] & ~sel_grant_o[s][d];
      end
    end
  end

  // Heads come from the next state so they line up with vld_mask_o.
  assign w_head_rem[0] = w_vld_n;
  for (genvar h = 0; h < HEAD_CNT; h++) begin : g_head
    age_order_pick u_pick (
      .i_mat   (w_older_n),
      .i_mask  (w_head_rem[h]),
      .o_grant (w_head_n[h])
    );
    if (h < HEAD_CNT - 1) begin : g_rem
      assign w_head_rem[h+1] = w_head_rem[h] & ~w_head_n[h];
    end
  end

  // Ordering state and heads, clock-enabled by any queue activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= '0;
      r_older <= '0;
      r_head  <= '0;
    end else if (w_upd) begin
      r_vld   <= w_vld_n;
      r_older <= w_older_n;
      for (int h = 0; h < HEAD_CNT; h++) begin
        r_head[h] <= w_head_n[h];
      end
    end
  end

  assign vld_mask_o  = r_vld;
  assign head_mask_o = r_head;

  age_order_chk #(
    .ENQ_WIDTH (ENQ_WIDTH)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .enq_vld_i  (enq_vld_i),
    .enq_tag_i  (enq_tag_i),
    .deq_mask_i (w_deq_mask),
    .vld_i      (r_vld),
    .older_i    (r_older)
  );

endmodule
